// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encodings, arbiter FSM states and the
// helper that decodes a flit's type field.
package noc_pkg;

  typedef enum logic [1:0] {
    FLIT_SINGLE = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_BODY   = 2'b10,
    FLIT_TAIL   = 2'b11
  } flit_type_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Callers pass the two MSBs of the flit, so the helper is width-agnostic.
  function automatic flit_type_t flit_type_of(input logic [1:0] type_bits);
    return flit_type_t'(type_bits);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    // Walk from the farthest offset back towards i_ptr so the nearest wins.
    for (int k = N - 1; k >= 0; k--) begin
      int p;
      p = int'(i_ptr) + k;
      if (p >= N) p = p - N;
      if (i_req[p]) begin
        o_grant    = '0;
        o_grant[p] = 1'b1;
        o_idx      = IW'(p);
        o_valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_out_arbiter.sv
// Output-link arbiter: round-robin between input FIFOs at packet granularity,
// with credit-based flow control towards the downstream buffer.
module noc_out_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FLIT_WIDTH = 32,
  parameter int CREDITS    = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              i_fifo_empty,
  input  logic [NUM_REQ*FLIT_WIDTH-1:0]   i_fifo_read_data,
  output logic [NUM_REQ-1:0]              o_fifo_read,
  input  logic                            i_credit_return,
  output logic                            o_flit_valid,
  output logic [FLIT_WIDTH-1:0]           o_flit,
  output logic [NUM_REQ-1:0]              o_grant,
  output logic [$clog2(CREDITS+1)-1:0]    o_credits
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [CW-1:0] CRED_ONE = CW'(1);

  arb_state_t             r_state;
  logic [IW-1:0]          r_rr_ptr;
  logic [IW-1:0]          r_owner;
  logic [CW-1:0]          r_credits;
  logic                   r_flit_valid;
  logic [FLIT_WIDTH-1:0]  r_flit;

  arb_state_t             w_state_next;
  logic [IW-1:0]          w_rr_next;
  logic [IW-1:0]          w_owner_next;
  logic [NUM_REQ-1:0]     w_read;
  logic                   w_read_any;
  logic [IW-1:0]          w_sel_idx;
  logic [FLIT_WIDTH-1:0]  w_sel_flit;
  flit_type_t             w_sel_type;
  logic                   w_has_credit;
  logic [NUM_REQ-1:0]     w_owner_onehot;
  logic [NUM_REQ-1:0]     w_pick_grant;
  logic [IW-1:0]          w_pick_idx;
  logic                   w_pick_valid;
  logic [FLIT_WIDTH-1:0]  w_flits [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_flits[gi] = i_fifo_read_data[gi*FLIT_WIDTH +: FLIT_WIDTH];
  end

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    if (p == IW'(NUM_REQ - 1)) return '0;
    return p + IW'(1);
  endfunction

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .i_req   (~i_fifo_empty),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_has_credit   = (r_credits != '0);
  assign w_owner_onehot = NUM_REQ'(1) << r_owner;

  always_comb begin
    w_read       = '0;
    w_sel_idx    = r_owner;
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_rr_next    = r_rr_ptr;
    // Reads are held off during reset so an in-flight packet is abandoned.
    case (r_state)
      ARB_IDLE: begin
        if (rst_n && w_has_credit && w_pick_valid) begin
          w_read    = w_pick_grant;
          w_sel_idx = w_pick_idx;
        end
      end
      ARB_LOCKED: begin
        if (rst_n && w_has_credit && !i_fifo_empty[r_owner]) begin
          w_read = w_owner_onehot;
        end
      end
      default: ;
    endcase

    w_read_any = |w_read;
    w_sel_flit = w_flits[w_sel_idx];
    w_sel_type = flit_type_of(w_sel_flit[FLIT_WIDTH-1 -: 2]);

    // Out-of-order types are forwarded untouched and leave the FSM alone.
    if (w_read_any) begin
      case (r_state)
        ARB_IDLE: begin
          if (w_sel_type == FLIT_HEAD) begin
            w_state_next = ARB_LOCKED;
            w_owner_next = w_pick_idx;
          end else if (w_sel_type == FLIT_SINGLE) begin
            w_rr_next = ptr_inc(w_pick_idx);
          end
        end
        ARB_LOCKED: begin
          if (w_sel_type == FLIT_TAIL) begin
            w_state_next = ARB_IDLE;
            w_rr_next    = ptr_inc(r_owner);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ARB_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_rr_ptr <= w_rr_next;
      r_owner  <= w_owner_next;
    end
  end

  // A return that coincides with a read cancels out; returns saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits <= CRED_MAX;
    end else begin
      case ({w_read_any, i_credit_return})
        2'b10:   r_credits <= r_credits - CRED_ONE;
        2'b01:   if (r_credits != CRED_MAX) r_credits <= r_credits + CRED_ONE;
        default: r_credits <= r_credits;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flit_valid <= 1'b0;
      r_flit       <= '0;
    end else begin
      r_flit_valid <= w_read_any;
      if (w_read_any) r_flit <= w_sel_flit;
    end
  end

  assign o_fifo_read  = w_read;
  assign o_flit_valid = r_flit_valid;
  assign o_flit       = r_flit;
  assign o_credits    = r_credits;
  assign o_grant      = (r_state == ARB_LOCKED) ? w_owner_onehot : '0;

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Directed bench for noc_out_arbiter: a default instance (16 credits) and a
// 2-credit instance, each fed by simple FIFO models.
module tb_noc_out_arbiter;

  localparam logic [1:0] S = 2'b00, H = 2'b01, B = 2'b10, T = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ret_a, ret_b;
  logic [3:0]  empty_a, read_a, grant_a, empty_b, read_b, grant_b;
  logic [127:0] data_a, data_b;
  logic        valid_a, valid_b;
  logic [31:0] flit_a, flit_b;
  logic [4:0]  cred_a;
  logic [1:0]  cred_b;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_a [4][64];
  logic [31:0] mem_b [4][64];
  logic [5:0]  hd_a [4] = '{default: '0};
  logic [5:0]  tl_a [4] = '{default: '0};
  logic [5:0]  hd_b [4] = '{default: '0};
  logic [5:0]  tl_b [4] = '{default: '0};

  for (genvar gi = 0; gi < 4; gi++) begin : g_fifo
    assign empty_a[gi]          = (hd_a[gi] == tl_a[gi]);
    assign data_a[gi*32 +: 32]  = mem_a[gi][hd_a[gi]];
    assign empty_b[gi]          = (hd_b[gi] == tl_b[gi]);
    assign data_b[gi*32 +: 32]  = mem_b[gi][hd_b[gi]];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (read_a[i] === 1'b1) hd_a[i] <= hd_a[i] + 6'd1;
      if (read_b[i] === 1'b1) hd_b[i] <= hd_b[i] + 6'd1;
    end
  end

  noc_out_arbiter dut_a (
    .clk(clk), .rst_n(rst_n), .i_fifo_empty(empty_a), .i_fifo_read_data(data_a),
    .o_fifo_read(read_a), .i_credit_return(ret_a), .o_flit_valid(valid_a),
    .o_flit(flit_a), .o_grant(grant_a), .o_credits(cred_a)
  );

  noc_out_arbiter #(.NUM_REQ(4), .FLIT_WIDTH(32), .CREDITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_fifo_empty(empty_b), .i_fifo_read_data(data_b),
    .o_fifo_read(read_b), .i_credit_return(ret_b), .o_flit_valid(valid_b),
    .o_flit(flit_b), .o_grant(grant_b), .o_credits(cred_b)
  );

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [29:0] p);
    return {t, p};
  endfunction

  task automatic push_a(input int i, input logic [31:0] f);
    mem_a[i][tl_a[i]] = f;
    tl_a[i] = tl_a[i] + 6'd1;
  endtask

  task automatic push_b(input int i, input logic [31:0] f);
    mem_b[i][tl_b[i]] = f;
    tl_b[i] = tl_b[i] + 6'd1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ret_a = 1'b0; ret_b = 1'b0;
    push_a(3, mk(S, 30'h0A1));
    tick; tick;
    total++; if (read_a !== 4'b0000) begin bad++; $display("FAIL reset_read got=%b exp=0000", read_a); end
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
    total++; if (grant_a !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant_a); end
    total++; if (cred_a !== 5'd16) begin bad++; $display("FAIL reset_credits got=%0d exp=16", cred_a); end
    total++; if (flit_a !== 32'h0) begin bad++; $display("FAIL reset_flit got=%h exp=0", flit_a); end
    total++; if (cred_b !== 2'd2) begin bad++; $display("FAIL reset_credits_b got=%0d exp=2", cred_b); end
    rst_n = 1'b1;
    #1;
    total++; if (read_a !== 4'b1000) begin bad++; $display("FAIL post_reset_read got=%b exp=1000", read_a); end
    tick;
    total++; if (valid_a !== 1'b1) begin bad++; $display("FAIL post_reset_valid got=%b exp=1", valid_a); end
    total++; if (flit_a !== mk(S, 30'h0A1)) begin bad++; $display("FAIL post_reset_flit got=%h exp=%h", flit_a, mk(S, 30'h0A1)); end
    total++; if (cred_a !== 5'd15) begin bad++; $display("FAIL post_reset_credits got=%0d exp=15", cred_a); end
    tick;
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL valid_drop got=%b exp=0", valid_a); end
    total++; if (flit_a !== mk(S, 30'h0A1)) begin bad++; $display("FAIL flit_hold got=%h exp=%h", flit_a, mk(S, 30'h0A1)); end
  endtask

  task automatic test_single_rr;
    push_a(0, mk(S, 30'h10));
    push_a(2, mk(S, 30'h12));
    #1;
    total++; if (read_a !== 4'b0001) begin bad++; $display("FAIL rr_first_read got=%b exp=0001", read_a); end
    tick;
    total++; if (valid_a !== 1'b1 || flit_a !== mk(S, 30'h10)) begin bad++; $display("FAIL rr_first_flit got=%b/%h exp=1/%h", valid_a, flit_a, mk(S, 30'h10)); end
    total++; if (read_a !== 4'b0100) begin bad++; $display("FAIL rr_second_read got=%b exp=0100", read_a); end
    tick;
    total++; if (valid_a !== 1'b1 || flit_a !== mk(S, 30'h12)) begin bad++; $display("FAIL rr_second_flit got=%b/%h exp=1/%h", valid_a, flit_a, mk(S, 30'h12)); end
    total++; if (read_a !== 4'b0000) begin bad++; $display("FAIL rr_idle_read got=%b exp=0000", read_a); end
    tick;
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL rr_valid_drop got=%b exp=0", valid_a); end
    total++; if (cred_a !== 5'd13) begin bad++; $display("FAIL rr_credits got=%0d exp=13", cred_a); end
  endtask

  task automatic test_credits;
    ret_a = 1'b1;
    tick; tick; tick;
    ret_a = 1'b0;
    total++; if (cred_a !== 5'd16) begin bad++; $display("FAIL cred_return got=%0d exp=16", cred_a); end
    ret_a = 1'b1;
    tick;
    ret_a = 1'b0;
    total++; if (cred_a !== 5'd16) begin bad++; $display("FAIL cred_saturate got=%0d exp=16", cred_a); end
    for (int k = 0; k < 11; k++) push_a(1, mk(S, 30'h100 + 30'(k)));
    #1;
    total++; if (read_a !== 4'b0010) begin bad++; $display("FAIL cred_drain_read got=%b exp=0010", read_a); end
    repeat (11) tick;
    total++; if (cred_a !== 5'd5) begin bad++; $display("FAIL cred_drained got=%0d exp=5", cred_a); end
    total++; if (flit_a !== mk(S, 30'h10A)) begin bad++; $display("FAIL cred_drain_last got=%h exp=%h", flit_a, mk(S, 30'h10A)); end
    push_a(1, mk(S, 30'h1FF));
    ret_a = 1'b1;
    #1;
    total++; if (read_a !== 4'b0010) begin bad++; $display("FAIL cred_both_read got=%b exp=0010", read_a); end
    tick;
    ret_a = 1'b0;
    total++; if (cred_a !== 5'd5) begin bad++; $display("FAIL cred_both_hold got=%0d exp=5", cred_a); end
    total++; if (valid_a !== 1'b1) begin bad++; $display("FAIL cred_both_valid got=%b exp=1", valid_a); end
    ret_a = 1'b1;
    repeat (11) tick;
    ret_a = 1'b0;
    total++; if (cred_a !== 5'd16) begin bad++; $display("FAIL cred_restore got=%0d exp=16", cred_a); end
  endtask

  task automatic test_packet;
    push_a(1, mk(H, 30'h21));
    push_a(1, mk(B, 30'h22));
    push_a(1, mk(T, 30'h23));
    #1;
    total++; if (read_a !== 4'b0010 || grant_a !== 4'b0000) begin bad++; $display("FAIL pkt_head read/grant got=%b/%b exp=0010/0000", read_a, grant_a); end
    tick;
    push_a(3, mk(S, 30'h31));
    #1;
    total++; if (read_a !== 4'b0010 || grant_a !== 4'b0010) begin bad++; $display("FAIL pkt_body read/grant got=%b/%b exp=0010/0010", read_a, grant_a); end
    total++; if (flit_a !== mk(H, 30'h21)) begin bad++; $display("FAIL pkt_head_flit got=%h exp=%h", flit_a, mk(H, 30'h21)); end
    tick;
    total++; if (read_a !== 4'b0010 || grant_a !== 4'b0010) begin bad++; $display("FAIL pkt_tail read/grant got=%b/%b exp=0010/0010", read_a, grant_a); end
    total++; if (flit_a !== mk(B, 30'h22)) begin bad++; $display("FAIL pkt_body_flit got=%h exp=%h", flit_a, mk(B, 30'h22)); end
    tick;
    total++; if (read_a !== 4'b1000 || grant_a !== 4'b0000) begin bad++; $display("FAIL pkt_next read/grant got=%b/%b exp=1000/0000", read_a, grant_a); end
    total++; if (flit_a !== mk(T, 30'h23)) begin bad++; $display("FAIL pkt_tail_flit got=%h exp=%h", flit_a, mk(T, 30'h23)); end
    tick;
    total++; if (flit_a !== mk(S, 30'h31) || read_a !== 4'b0000) begin bad++; $display("FAIL pkt_after got=%h/%b exp=%h/0000", flit_a, read_a, mk(S, 30'h31)); end
    tick;
    total++; if (cred_a !== 5'd12) begin bad++; $display("FAIL pkt_credits got=%0d exp=12", cred_a); end
  endtask

  task automatic test_reset_mid;
    push_a(2, mk(H, 30'h41));
    push_a(2, mk(B, 30'h42));
    push_a(2, mk(T, 30'h43));
    #1;
    total++; if (read_a !== 4'b0100) begin bad++; $display("FAIL mid_head_read got=%b exp=0100", read_a); end
    tick;
    total++; if (grant_a !== 4'b0100 || read_a !== 4'b0100) begin bad++; $display("FAIL mid_locked grant/read got=%b/%b exp=0100/0100", grant_a, read_a); end
    rst_n = 1'b0;
    push_a(0, mk(S, 30'h50));
    #1;
    total++; if (valid_a !== 1'b0 || grant_a !== 4'b0000) begin bad++; $display("FAIL mid_reset valid/grant got=%b/%b exp=0/0000", valid_a, grant_a); end
    total++; if (cred_a !== 5'd16) begin bad++; $display("FAIL mid_reset_credits got=%0d exp=16", cred_a); end
    total++; if (read_a !== 4'b0000) begin bad++; $display("FAIL mid_reset_read got=%b exp=0000", read_a); end
    tick;
    total++; if (read_a !== 4'b0000) begin bad++; $display("FAIL mid_reset_hold_read got=%b exp=0000", read_a); end
    rst_n = 1'b1;
    #1;
    total++; if (read_a !== 4'b0001) begin bad++; $display("FAIL mid_restart_read got=%b exp=0001", read_a); end
    tick;
    total++; if (flit_a !== mk(S, 30'h50) || read_a !== 4'b0100) begin bad++; $display("FAIL mid_restart_flit got=%h/%b exp=%h/0100", flit_a, read_a, mk(S, 30'h50)); end
    tick;
    total++; if (flit_a !== mk(B, 30'h42) || grant_a !== 4'b0000 || read_a !== 4'b0100) begin bad++; $display("FAIL mid_orphan_body got=%h/%b/%b exp=%h/0000/0100", flit_a, grant_a, read_a, mk(B, 30'h42)); end
    tick;
    total++; if (flit_a !== mk(T, 30'h43) || read_a !== 4'b0000 || grant_a !== 4'b0000) begin bad++; $display("FAIL mid_orphan_tail got=%h/%b/%b exp=%h/0000/0000", flit_a, read_a, grant_a, mk(T, 30'h43)); end
    tick;
    total++; if (cred_a !== 5'd13) begin bad++; $display("FAIL mid_credits got=%0d exp=13", cred_a); end
  endtask

  task automatic test_back_to_back;
    push_a(3, mk(S, 30'h60));
    #1;
    total++; if (read_a !== 4'b1000) begin bad++; $display("FAIL b2b_align_read got=%b exp=1000", read_a); end
    tick; tick;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) push_a(i, mk(S, 30'h70 + 30'(r * 4 + i)));
    for (int c = 0; c < 8; c++) begin
      logic [3:0] exp_rd;
      exp_rd = 4'b0001 << (c % 4);
      #1;
      total++; if (read_a !== exp_rd) begin bad++; $display("FAIL b2b_read[%0d] got=%b exp=%b", c, read_a, exp_rd); end
      tick;
      total++; if (flit_a !== mk(S, 30'h70 + 30'(c))) begin bad++; $display("FAIL b2b_flit[%0d] got=%h exp=%h", c, flit_a, mk(S, 30'h70 + 30'(c))); end
    end
    total++; if (read_a !== 4'b0000 || cred_a !== 5'd4) begin bad++; $display("FAIL b2b_end read/credits got=%b/%0d exp=0000/4", read_a, cred_a); end
  endtask

  task automatic test_credit_stall;
    push_b(0, mk(H, 30'h81));
    push_b(0, mk(B, 30'h82));
    push_b(0, mk(B, 30'h83));
    push_b(0, mk(T, 30'h84));
    #1;
    total++; if (read_b !== 4'b0001) begin bad++; $display("FAIL stall_first_read got=%b exp=0001", read_b); end
    tick;
    total++; if (read_b !== 4'b0001 || cred_b !== 2'd1) begin bad++; $display("FAIL stall_second read/credits got=%b/%0d exp=0001/1", read_b, cred_b); end
    tick;
    total++; if (read_b !== 4'b0000 || cred_b !== 2'd0) begin bad++; $display("FAIL stall_empty read/credits got=%b/%0d exp=0000/0", read_b, cred_b); end
    total++; if (valid_b !== 1'b1 || flit_b !== mk(B, 30'h82)) begin bad++; $display("FAIL stall_body_flit got=%b/%h exp=1/%h", valid_b, flit_b, mk(B, 30'h82)); end
    tick;
    total++; if (valid_b !== 1'b0 || read_b !== 4'b0000) begin bad++; $display("FAIL stall_hold valid/read got=%b/%b exp=0/0000", valid_b, read_b); end
    ret_b = 1'b1;
    #1;
    total++; if (read_b !== 4'b0000) begin bad++; $display("FAIL stall_return_same_cycle got=%b exp=0000", read_b); end
    tick;
    ret_b = 1'b0;
    #1;
    total++; if (read_b !== 4'b0001 || cred_b !== 2'd1) begin bad++; $display("FAIL stall_resume read/credits got=%b/%0d exp=0001/1", read_b, cred_b); end
    tick;
    total++; if (valid_b !== 1'b1 || flit_b !== mk(B, 30'h83)) begin bad++; $display("FAIL stall_resume_flit got=%b/%h exp=1/%h", valid_b, flit_b, mk(B, 30'h83)); end
    total++; if (read_b !== 4'b0000 || cred_b !== 2'd0) begin bad++; $display("FAIL stall_again read/credits got=%b/%0d exp=0000/0", read_b, cred_b); end
    tick;
    total++; if (valid_b !== 1'b0) begin bad++; $display("FAIL stall_one_only got=%b exp=0", valid_b); end
  endtask

  initial begin
    test_reset;
    test_single_rr;
    test_credits;
    test_packet;
    test_reset_mid;
    test_back_to_back;
    test_credit_stall;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
